// File: rtl/lut_mac_ctrl.sv
// lut_mac_ctrl: sequencer for the 16-entry LUT select datapath of the BitNet CiM operator.
// Latency: last weight handshake at edge E -> done_o in the cycle after E; zero-group run -> done_o the cycle after start.
// Backpressure: valid/ready on LUT writes and weight indices; a stall (valid low) holds all state; readies depend on state only.
//
// Ports:
//   clk_i, rst_n_i                  clock, asynchronous active-low reset
//   start_i, reuse_lut_i,           run request with its options, sampled only in IDLE
//   group_num_i
//   lut_wr_valid_i/ready_o/data_i   LUT entry stream, entries 0..15 in order (ready only in LOAD)
//   lut_entries_o                   stored LUT, entry k at [k*LUT_W +: LUT_W], feeds the external mux
//   w_valid_i/ready_o/data_i        weight index stream (ready only in COMPUTE)
//   weight_o                        mux select, combinational copy of w_data_i
//   lut_sel_i                       mux output returned in the same cycle
//   acc_o, done_o, busy_o           accumulator, one-cycle done pulse, not-idle flag
//   sat_o                           sticky clip flag, present only when LUT_ACC_SAT_EN is defined
//
// Build option: define LUT_ACC_SAT_EN for saturating accumulation plus sat_o;
// without it the accumulator wraps modulo 2**ACC_W.

module lut_mac_ctrl #(
  parameter int LUT_W = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  reuse_lut_i,
  input  logic [CNT_W-1:0]      group_num_i,
  input  logic                  lut_wr_valid_i,
  output logic                  lut_wr_ready_o,
  input  logic [LUT_W-1:0]      lut_wr_data_i,
  output logic [16*LUT_W-1:0]   lut_entries_o,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [3:0]            w_data_i,
  output logic [3:0]            weight_o,
  input  logic [LUT_W-1:0]      lut_sel_i,
  output logic [ACC_W-1:0]      acc_o,
  output logic                  done_o,
  output logic                  busy_o
`ifdef LUT_ACC_SAT_EN
  ,
  output logic                  sat_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [3:0]          ld_cnt;
  logic [CNT_W-1:0]    g_cnt;
  logic [CNT_W-1:0]    g_cnt_inc;
  logic [CNT_W-1:0]    g_num;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nxt;
  logic [ACC_W-1:0]    sel_ext;
  logic [LUT_W-1:0]    lut_mem [16];

  logic                start_acc;
  logic                ld_hs;
  logic                w_hs;

  // Handshake qualifiers; readies are pure functions of state.
  assign lut_wr_ready_o = (state == LOAD);
  assign w_ready_o      = (state == COMPUTE);
  assign done_o         = (state == DONE);
  assign busy_o         = (state != IDLE);

  assign start_acc = (state == IDLE) && start_i;
  assign ld_hs     = lut_wr_valid_i && lut_wr_ready_o;
  assign w_hs      = w_valid_i && w_ready_o;

  assign weight_o  = w_data_i;
  assign acc_o     = acc;
  assign g_cnt_inc = g_cnt + 1'b1;

  // Sign-extend the selected LUT entry to accumulator width.
  assign sel_ext = ACC_W'($signed(lut_sel_i));

  genvar gk;
  generate
    for (gk = 0; gk < 16; gk++) begin : g_pack
      assign lut_entries_o[gk*LUT_W +: LUT_W] = lut_mem[gk];
    end
  endgenerate

`ifdef LUT_ACC_SAT_EN
  // One guard bit: overflow iff the two top bits of the widened sum differ.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           clip;
  logic           sat;

  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {sel_ext[ACC_W-1], sel_ext};
    acc_nxt  = sum_wide[ACC_W-1:0];
    clip     = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      clip    = 1'b1;
      acc_nxt = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat <= 1'b0;
    end else if (start_acc) begin
      sat <= 1'b0;
    end else if (w_hs && clip) begin
      sat <= 1'b1;
    end
  end

  assign sat_o = sat;
`else
  assign acc_nxt = acc + sel_ext;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (group_num_i == '0) begin
            state_nxt = DONE;
          end else if (reuse_lut_i) begin
            state_nxt = COMPUTE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (ld_hs && (ld_cnt == 4'd15)) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (w_hs && (g_cnt_inc == g_num)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      ld_cnt <= '0;
      g_cnt  <= '0;
      g_num  <= '0;
      acc    <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        acc    <= '0;
        g_num  <= group_num_i;
        g_cnt  <= '0;
        ld_cnt <= '0;
      end
      // ld_cnt is 4 bits, so the 16th write wraps it back to 0.
      if (ld_hs) begin
        ld_cnt <= ld_cnt + 1'b1;
      end
      if (w_hs) begin
        acc   <= acc_nxt;
        g_cnt <= g_cnt_inc;
      end
    end
  end

  // LUT storage survives across runs; only LOAD rewrites it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < 16; k++) begin
        lut_mem[k] <= '0;
      end
    end else if (ld_hs) begin
      lut_mem[ld_cnt] <= lut_wr_data_i;
    end
  end

endmodule
